reg_file_mp: RTL

//   Parametrised CPU register file for the MSP430 core. It has two read ports
//   (source with constant generator, destination raw) and two prioritised write

---
 rtl/reg_file_mp.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Brief    : MSP430 register file with two read ports (source with constant
//            generator), two prioritised write ports, PC/SP/SR update paths,
//            optional write-to-read bypass and a sticky PC-fault flag.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
    parameter int                DATA_W = 16,
    parameter int                NREGS  = 16,
    parameter logic [DATA_W-1:0] PC_MIN = 'h0200,
    parameter int                BYPASS = 1,
    localparam int               AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rst_vec,
    input  logic [AW-1:0]     rs_addr,
    input  logic [1:0]        rs_as,
    output logic [DATA_W-1:0] rs_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr0_en,
    input  logic [AW-1:0]     wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [AW-1:0]     wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              pc_we,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              sp_we,
    input  logic [DATA_W-1:0] sp_in,
    input  logic              flags_we,
    input  logic [3:0]        flags_in,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] sp,
    output logic [DATA_W-1:0] sr,
    output logic              wr_collide,
    output logic              pc_fault
);

    localparam logic [DATA_W-1:0] c_EVEN_MASK = ~DATA_W'(1);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [DATA_W-1:0] w_next [NREGS];
    logic [NREGS-1:0]  w_we;
    logic [NREGS-1:0]  w_trap;
    logic              r_collide;
    logic              r_fault;

    // Per-register next value: wr0 > wr1 > dedicated path, then PC/SP rules.
    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        logic              w_hit0;
        logic              w_hit1;
        logic              w_ded;
        logic [DATA_W-1:0] w_ded_val;
        logic [DATA_W-1:0] w_sel;
        logic [DATA_W-1:0] w_val;
        logic              w_bad_pc;

        assign w_hit0 = wr0_en && (wr0_addr == AW'(i));
        assign w_hit1 = wr1_en && (wr1_addr == AW'(i));

        always_comb begin
            w_ded     = 1'b0;
            w_ded_val = r_regs[i];
            if (i == 0) begin
                w_ded     = pc_we;
                w_ded_val = pc_in;
            end else if (i == 1) begin
                w_ded     = sp_we;
                w_ded_val = sp_in;
            end else if (i == 2) begin
                w_ded        = flags_we;
                w_ded_val[8] = flags_in[3];
                w_ded_val[2] = flags_in[2];
                w_ded_val[1] = flags_in[1];
                w_ded_val[0] = flags_in[0];
            end
        end

        always_comb begin
            w_sel    = w_hit0 ? wr0_data : (w_hit1 ? wr1_data : w_ded_val);
            w_val    = w_sel;
            w_bad_pc = 1'b0;
            if (i == 0) begin
                w_val = w_sel & c_EVEN_MASK;
                if (w_val < PC_MIN) begin
                    w_val    = rst_vec & c_EVEN_MASK;
                    w_bad_pc = 1'b1;
                end
            end else if (i == 1) begin
                w_val = w_sel & c_EVEN_MASK;
            end
        end

        // R3 is the constant-generator slot and never stores anything.
        assign w_we[i]   = !rst && (i != 3) && (w_hit0 || w_hit1 || w_ded);
        assign w_next[i] = w_val;
        assign w_trap[i] = w_bad_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_regs[0] <= rst_vec & c_EVEN_MASK;
            r_collide <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_we[i]) begin
                    r_regs[i] <= w_next[i];
                end
            end
            r_collide <= wr0_en && wr1_en && (wr0_addr == wr1_addr);
            if (|(w_trap & w_we)) begin
                r_fault <= 1'b1;
            end
        end
    end

    // Reads: out-of-range addresses match no register and fall through to 0.
    always_comb begin
        rs_data = '0;
        rd_data = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rs_addr == AW'(i)) begin
                rs_data = (BYPASS != 0 && w_we[i]) ? w_next[i] : r_regs[i];
            end
            if (rd_addr == AW'(i)) begin
                rd_data = (BYPASS != 0 && w_we[i]) ? w_next[i] : r_regs[i];
            end
        end
        if (rs_addr == AW'(2)) begin
            case (rs_as)
                2'b01:   rs_data = '0;
                2'b10:   rs_data = DATA_W'(4);
                2'b11:   rs_data = DATA_W'(8);
                default: ;
            endcase
        end else if (rs_addr == AW'(3)) begin
            case (rs_as)
                2'b00:   rs_data = '0;
                2'b01:   rs_data = DATA_W'(1);
                2'b10:   rs_data = DATA_W'(2);
                default: rs_data = '1;
            endcase
        end
    end

    assign pc         = r_regs[0];
    assign sp         = r_regs[1];
    assign sr         = r_regs[2];
    assign wr_collide = r_collide;
    assign pc_fault   = r_fault;

endmodule
`default_nettype wire
